// File: rtl/demux1ne4_pkg.sv
// Shared constants and slot state type for the buffered 1-to-4 demultiplexer.
package demux1ne4_pkg;

  localparam int unsigned DEMUX_WIDTH = 24;
  localparam int unsigned DEMUX_SLOTS = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One output slot: data register plus EMPTY/FULL handshake FSM.
module demux_slot
  import demux1ne4_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  slot_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_nxt;
  end

  // A write wins over a same-cycle drain so the slot stays full with the new word.
  always_comb begin
    state_nxt = state;
    if (wr)
      state_nxt = SLOT_FULL;
    else if (state == SLOT_FULL && rdy)
      state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst)     dout <= '0;
    else if (wr) dout <= din;
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux1ne4_buf.sv
// Buffered 1-to-4 demultiplexer top: write decode, ready select, slot array.
// Optional DEMUX1NE4_OVERWRITE_EN: always ready, full slots are overwritten and counted.
module demux1ne4_buf
  import demux1ne4_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       Hyrja,
  input  logic [1:0]             S,
  input  logic                   HyrjaValid,
  output logic                   HyrjaReady,
  output logic [WIDTH-1:0]       Dalja0,
  output logic [WIDTH-1:0]       Dalja1,
  output logic [WIDTH-1:0]       Dalja2,
  output logic [WIDTH-1:0]       Dalja3,
  output logic [DEMUX_SLOTS-1:0] DaljaValid,
  input  logic [DEMUX_SLOTS-1:0] DaljaReady
`ifdef DEMUX1NE4_OVERWRITE_EN
  ,
  output logic [7:0]             Mbishkrime
`endif
);

  logic                   acc;
  logic [DEMUX_SLOTS-1:0] wr;
  logic [WIDTH-1:0]       dout [DEMUX_SLOTS];

`ifdef DEMUX1NE4_OVERWRITE_EN
  assign HyrjaReady = 1'b1;
`else
  assign HyrjaReady = ~DaljaValid[S] | DaljaReady[S];
`endif

  assign acc = HyrjaValid & HyrjaReady;

  always_comb begin
    wr = '0;
    if (acc) wr[S] = 1'b1;
  end

  for (genvar g = 0; g < DEMUX_SLOTS; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (Clock),
      .rst   (Reset),
      .wr    (wr[g]),
      .din   (Hyrja),
      .rdy   (DaljaReady[g]),
      .dout  (dout[g]),
      .valid (DaljaValid[g])
    );
  end

  assign Dalja0 = dout[0];
  assign Dalja1 = dout[1];
  assign Dalja2 = dout[2];
  assign Dalja3 = dout[3];

`ifdef DEMUX1NE4_OVERWRITE_EN
  // Only a write landing on a full slot that is not draining discards a word.
  always_ff @(posedge Clock) begin
    if (Reset)
      Mbishkrime <= '0;
    else if (acc && DaljaValid[S] && !DaljaReady[S] && Mbishkrime != 8'hFF)
      Mbishkrime <= Mbishkrime + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux1ne4_buf.sv
// Directed self-checking bench for demux1ne4_buf (default and DEMUX1NE4_OVERWRITE_EN builds).
module tb_demux1ne4_buf;

  localparam int unsigned W = 24;
`ifdef DEMUX1NE4_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] Hyrja;
  logic [1:0]   S;
  logic         HyrjaValid;
  logic         HyrjaReady;
  logic [W-1:0] Dalja0, Dalja1, Dalja2, Dalja3;
  logic [3:0]   DaljaValid;
  logic [3:0]   DaljaReady;
`ifdef DEMUX1NE4_OVERWRITE_EN
  logic [7:0]   Mbishkrime;
`endif

  int vectors = 0;
  int miscompares = 0;

  demux1ne4_buf #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Hyrja      (Hyrja),
    .S          (S),
    .HyrjaValid (HyrjaValid),
    .HyrjaReady (HyrjaReady),
    .Dalja0     (Dalja0),
    .Dalja1     (Dalja1),
    .Dalja2     (Dalja2),
    .Dalja3     (Dalja3),
    .DaljaValid (DaljaValid),
    .DaljaReady (DaljaReady)
`ifdef DEMUX1NE4_OVERWRITE_EN
    ,
    .Mbishkrime (Mbishkrime)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before sampling/driving.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  logic [W-1:0] bb [4];

  initial begin
    Reset = 1'b1; HyrjaValid = 1'b1; Hyrja = 24'h123456; S = 2'd0; DaljaReady = 4'b0000;
    tick();
    tick();
    check("rst_valid", 32'(DaljaValid), 32'h0);
    check("rst_d0", 32'(Dalja0), 32'h0);
    check("rst_d1", 32'(Dalja1), 32'h0);
    check("rst_d2", 32'(Dalja2), 32'h0);
    check("rst_d3", 32'(Dalja3), 32'h0);

    Reset = 1'b0; HyrjaValid = 1'b0;
    #1;
    check("post_rst_ready", 32'(HyrjaReady), 32'h1);

    // Single write to slot 2, then a blocked (or overwriting) second write.
    HyrjaValid = 1'b1; S = 2'd2; Hyrja = 24'hABCDEF;
    #1;
    check("w2_ready", 32'(HyrjaReady), 32'h1);
    tick();
    Hyrja = 24'h111111;
    #1;
    check("w2_valid", 32'(DaljaValid), 32'h4);
    check("w2_data", 32'(Dalja2), 32'hABCDEF);
    check("w2_full_ready", 32'(HyrjaReady), OVW ? 32'h1 : 32'h0);
    tick();
    HyrjaValid = 1'b0;
    check("w2_hold_data", 32'(Dalja2), OVW ? 32'h111111 : 32'hABCDEF);
    check("w2_hold_valid", 32'(DaljaValid), 32'h4);

    // Pass-through: write slot 1 while it drains.
    HyrjaValid = 1'b1; S = 2'd1; Hyrja = 24'h000001;
    tick();
    Hyrja = 24'h000002; DaljaReady = 4'b0010;
    #1;
    check("pt_ready", 32'(HyrjaReady), 32'h1);
    tick();
    HyrjaValid = 1'b0; DaljaReady = 4'b0000;
    check("pt_valid", 32'(DaljaValid), 32'h6);
    check("pt_data", 32'(Dalja1), 32'h000002);

    // Drain everything; data must persist.
    DaljaReady = 4'b1111;
    tick();
    DaljaReady = 4'b0000;
    check("drain_valid", 32'(DaljaValid), 32'h0);
    check("drain_keep1", 32'(Dalja1), 32'h000002);

    // Back-to-back writes to all four slots.
    bb[0] = 24'hA00000; bb[1] = 24'hA00011; bb[2] = 24'hA00222; bb[3] = 24'hA03333;
    for (int i = 0; i < 4; i++) begin
      HyrjaValid = 1'b1; S = 2'(i); Hyrja = bb[i];
      #1;
      check("b2b_ready", 32'(HyrjaReady), 32'h1);
      tick();
    end
    HyrjaValid = 1'b0;
    check("b2b_valid", 32'(DaljaValid), 32'hF);
    check("b2b_d0", 32'(Dalja0), 32'hA00000);
    check("b2b_d1", 32'(Dalja1), 32'hA00011);
    check("b2b_d2", 32'(Dalja2), 32'hA00222);
    check("b2b_d3", 32'(Dalja3), 32'hA03333);
    DaljaReady = 4'b1111;
    tick();
    DaljaReady = 4'b0000;
    check("b2b_drain_valid", 32'(DaljaValid), 32'h0);
    check("b2b_drain_keep3", 32'(Dalja3), 32'hA03333);

    // Independent write to slot 0 while slot 3 (refilled) is held.
    HyrjaValid = 1'b1; S = 2'd3; Hyrja = 24'h333333;
    tick();
    S = 2'd0; Hyrja = 24'h000AAA;
    tick();
    check("indep_valid", 32'(DaljaValid), 32'h9);
    check("indep_d0", 32'(Dalja0), 32'h000AAA);

    // Reset dominates a pending write.
    Reset = 1'b1; S = 2'd1; Hyrja = 24'h777777;
    tick();
    Reset = 1'b0; HyrjaValid = 1'b0;
    check("rst2_valid", 32'(DaljaValid), 32'h0);
    check("rst2_d1", 32'(Dalja1), 32'h0);
    check("rst2_d3", 32'(Dalja3), 32'h0);
    tick();
    check("rst2_stay_empty", 32'(DaljaValid), 32'h0);

`ifdef DEMUX1NE4_OVERWRITE_EN
    check("ovw_cnt_rst", 32'(Mbishkrime), 32'h0);
    // First write fills the slot; the remaining 299 are overwrites, saturating at 255.
    for (int i = 1; i <= 300; i++) begin
      HyrjaValid = 1'b1; S = 2'd0; Hyrja = 24'(i * 7);
      tick();
    end
    HyrjaValid = 1'b0;
    check("ovw_data", 32'(Dalja0), 32'(300 * 7));
    check("ovw_cnt", 32'(Mbishkrime), 32'hFF);
    check("ovw_valid", 32'(DaljaValid), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux1ne4_buf.md
# demux1ne4_buf

Buffered 1-to-4 demultiplexer: routes a WIDTH-bit word arriving on a single valid/ready input channel to one of four output slots chosen by a 2-bit select. Each slot holds one word until its consumer drains it. It is the write-side counterpart of the 4-to-1 selection path in the 24-bit CPU datapath, distributing one producer (ALU/bus result) to four destinations (register-bank write ports, I/O latches).

## Interface
Parameters:
- WIDTH, 24, data width of input and each output slot

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Hyrja  in  WIDTH  input data word
- S  in  2  destination slot select (0..3)
- HyrjaValid  in  1  producer offers Hyrja/S this cycle
- HyrjaReady  out  1  block accepts the offered word this cycle
- Dalja0..Dalja3  out  WIDTH each  slot data outputs
- DaljaValid  out  4  bit i: slot i holds an undrained word
- DaljaReady  in  4  bit i: consumer i takes slot i this cycle
- Mbishkrime  out  8  saturating overwrite count (only with DEMUX1NE4_OVERWRITE_EN; absent otherwise)

## Operation
- Per-slot two-state FSM: SLOT_EMPTY, SLOT_FULL. DaljaValid[i] = (state_i == SLOT_FULL).
- Write accept: acc = HyrjaValid & HyrjaReady. On acc, slot S loads Hyrja and goes SLOT_FULL.
- Drain: slot i with DaljaValid[i] & DaljaReady[i] goes SLOT_EMPTY unless written the same cycle.
- Default ready: HyrjaReady = ~DaljaValid[S] | DaljaReady[S] (pass-through when target slot drains this cycle).
- Simultaneous drain and write of the same slot: old word leaves, new word loaded, slot stays SLOT_FULL.
- Writes and drains of different slots are independent; all four slots may drain in one cycle.
- Only slot S is affected by a write; other slots' data registers hold.
- Dalja outputs are registered and change only on a load. Data persists after a drain; only DaljaValid clears.
- S and Hyrja are ignored when HyrjaValid = 0.

## Timing
- Reset (synchronous, dominates all other inputs): all slots SLOT_EMPTY, DaljaValid = 0, Dalja0..3 = 0, Mbishkrime = 0. HyrjaReady = 1 in the first cycle after reset, since all slots are empty.
- Latency: a word accepted at edge N appears on Dalja[S] with DaljaValid[S] = 1 after edge N.
- Throughput: one word per cycle. Continuous writes to a single slot sustain one per cycle only while DaljaReady[S] = 1.
- HyrjaReady is combinational from S, DaljaValid and DaljaReady. There is no combinational path from Hyrja to any output.
- Producer rule: Hyrja/S held stable while HyrjaValid = 1 and HyrjaReady = 0.

## Configuration
- DEMUX1NE4_OVERWRITE_EN defined:
  - HyrjaReady is tied to 1.
  - A write to a SLOT_FULL slot that is not draining replaces its word; slot stays SLOT_FULL.
  - Each such replacement increments Mbishkrime, which saturates at 255.
- Not defined:
  - Backpressure as in Operation; no overwrite ever occurs.
  - Port Mbishkrime and its counter are not present.

## Structure
- Package demux1ne4_pkg:
  - constant DEMUX_WIDTH = 24
  - constant DEMUX_SLOTS = 4
  - slot state enum {SLOT_EMPTY, SLOT_FULL}
- One sub-module, demux_slot: a single slot's data register, FSM, load/drain handshake and valid output. Instantiated four times.
- Top level holds the 2-to-4 write-enable decode, HyrjaReady select and optional overwrite counter.

## Test plan
- Reset with HyrjaValid = 1: DaljaValid = 4'b0000, Dalja0..3 = 0, no load. After Reset drops, HyrjaReady = 1.
- Write 24'hABCDEF to S=2, DaljaReady = 0: next cycle DaljaValid = 4'b0100, Dalja2 = 24'hABCDEF. A second write to S=2 sees HyrjaReady = 0 and Dalja2 is unchanged.
- Write to S=1 while slot 1 is full with DaljaReady[1] = 1: HyrjaReady = 1, new word loaded, DaljaValid[1] stays 1.
- Back-to-back writes S=0,1,2,3 with DaljaReady = 0: four accepts in four cycles, DaljaValid = 4'b1111. Then DaljaReady = 4'b1111 for one cycle gives DaljaValid = 4'b0000 and data is retained.
- Reset asserted while slot 3 is full and a write is pending: next cycle all slots are empty and the write is dropped.
- With DEMUX1NE4_OVERWRITE_EN: 300 writes to a full, non-draining slot 0. Dalja0 equals the last word and Mbishkrime = 255.
